// File: rtl/pwm_audio_out.sv
// pwm_audio_out: buffered, volume-scaled single-bit PWM audio output.
// One sample per 256-cycle period, with underrun and new-duty pulses.
module pwm_audio_out #(
  parameter int PWM_BITS      = 8,
  parameter int MAX_AMPLITUDE = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS:0]   sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [4:0]          volume,
  input  logic                mute,
  output logic                pwm_out,
  output logic                sample_tick,
  output logic                underrun
);

  localparam int PW = PWM_BITS + 5;

  localparam logic [PWM_BITS:0] MAX_W =
    (PWM_BITS+1)'(MAX_AMPLITUDE);
  localparam logic [PWM_BITS-1:0] MAX_N =
    PWM_BITS'(MAX_AMPLITUDE);
  localparam logic [PWM_BITS-1:0] CNT_LAST =
    {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] CNT_CONSUME =
    CNT_LAST - 1'b1;
  localparam logic [PWM_BITS-1:0] DUTY_MID =
    PWM_BITS'(1 << (PWM_BITS - 1));

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] sbuf;
  logic                buf_full;
  logic                pend;
  logic [PW-1:0]       prod;
  logic [PWM_BITS-1:0] duty;

  logic [PWM_BITS-1:0] clamped;
  logic [4:0]          vol_sat;
  logic                accept;
  logic                consume;
  logic                at_last;

  assign sample_ready = !buf_full;
  assign accept       = sample_valid && sample_ready;
  assign at_last      = (cnt == CNT_LAST);
  assign consume      = (cnt == CNT_CONSUME);

  // Clamp incoming sample and saturate gain at unity (16/16).
  always_comb begin
    clamped = sample_in[PWM_BITS-1:0];
    if (sample_in > MAX_W)
      clamped = MAX_N;
    vol_sat = volume;
    if (volume > 5'd16)
      vol_sat = 5'd16;
  end

  // Free-running period counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // One-entry buffer; drained only at the consume cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbuf     <= '0;
      buf_full <= 1'b0;
    end else if (consume && buf_full) begin
      buf_full <= 1'b0;
    end else if (accept) begin
      sbuf     <= clamped;
      buf_full <= 1'b1;
    end
  end

  // Scale stage: multiply at consume, load duty at period end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= '0;
      pend <= 1'b0;
      duty <= DUTY_MID;
    end else begin
      if (consume) begin
        pend <= buf_full;
        if (buf_full)
          prod <= {5'b0, sbuf} * {PWM_BITS'(0), vol_sat};
      end
      if (at_last && pend)
        duty <= PWM_BITS'(prod >> 4);
    end
  end

  // Registered PWM pin and boundary status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out     <= 1'b0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      pwm_out     <= (cnt < duty) && !mute;
      sample_tick <= at_last && pend;
      underrun    <= at_last && !pend;
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb_pwm_audio_out: directed vectors for pwm_audio_out.
// Counts PWM high cycles per period against hand-computed duties.
module tb_pwm_audio_out;

  logic       clk;
  logic       rst;
  logic [8:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;
  logic [4:0] volume;
  logic       mute;
  logic       pwm_out;
  logic       sample_tick;
  logic       underrun;

  pwm_audio_out dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .volume       (volume),
    .mute         (mute),
    .pwm_out      (pwm_out),
    .sample_tick  (sample_tick),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] s;
    logic [4:0] v;
    int         d;
  } vec_t;

  vec_t tbl [8];

  int nvec;
  int nerr;
  int tb_cnt;
  int feed_at;
  int feed_val;
  int mute_at;
  logic mute_val;
  int sq [3];
  int sidx;
  logic stream_on;
  int accepts;

  task automatic check(input string nm, input int act,
                       input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    logic acc;
    acc = stream_on && sample_valid && sample_ready;
    @(negedge clk);
    tb_cnt = (tb_cnt + 1) % 256;
    if (acc) begin
      accepts++;
      sidx++;
      if (sidx < 3) begin
        sample_in = 9'(sq[sidx]);
      end else begin
        sample_valid = 1'b0;
        stream_on = 1'b0;
      end
    end
  endtask

  task automatic goto(input int c);
    while (tb_cnt != c) tick();
  endtask

  task automatic run_period(input string nm, input int exp_hi,
                            input int exp_tk, input int exp_ur);
    int hi;
    int stray;
    logic fed;
    hi = 0;
    stray = 0;
    check({nm, "_tick"}, int'(sample_tick), exp_tk);
    check({nm, "_underrun"}, int'(underrun), exp_ur);
    for (int i = 0; i < 256; i++) begin
      fed = 1'b0;
      if (tb_cnt == feed_at) begin
        sample_valid = 1'b1;
        sample_in = 9'(feed_val);
        fed = 1'b1;
      end
      if (tb_cnt == mute_at) mute = mute_val;
      tick();
      if (fed) sample_valid = 1'b0;
      if (pwm_out) hi++;
      if (tb_cnt != 0 && (sample_tick || underrun)) stray++;
    end
    check({nm, "_high"}, hi, exp_hi);
    check({nm, "_stray"}, stray, 0);
    feed_at = -1;
    mute_at = -1;
  endtask

  task automatic apply_vec(input int k);
    int bad;
    string nm;
    nm = $sformatf("vec%0d", k);
    goto(10);
    sample_in = tbl[k].s;
    volume = tbl[k].v;
    sample_valid = 1'b1;
    check({nm, "_ready10"}, int'(sample_ready), 1);
    tick();
    sample_valid = 1'b0;
    bad = 0;
    while (tb_cnt != 255) begin
      if (sample_ready) bad++;
      tick();
    end
    check({nm, "_readylow"}, bad, 0);
    check({nm, "_ready255"}, int'(sample_ready), 1);
    tick();
    run_period(nm, tbl[k].d, 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got stuck want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{9'd64,  5'd16, 64};
    tbl[1] = '{9'd300, 5'd16, 255};
    tbl[2] = '{9'd255, 5'd31, 255};
    tbl[3] = '{9'd200, 5'd0,  0};
    tbl[4] = '{9'd17,  5'd3,  3};
    tbl[5] = '{9'd255, 5'd1,  15};
    tbl[6] = '{9'd100, 5'd17, 100};
    tbl[7] = '{9'd200, 5'd8,  100};

    nvec = 0;
    nerr = 0;
    feed_at = -1;
    feed_val = 0;
    mute_at = -1;
    mute_val = 1'b0;
    stream_on = 1'b0;
    sidx = 0;
    accepts = 0;
    rst = 1'b1;
    sample_in = '0;
    sample_valid = 1'b0;
    volume = 5'd16;
    mute = 1'b0;
    tb_cnt = 0;

    repeat (2) @(negedge clk);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_ready", int'(sample_ready), 1);
    check("rst_tick", int'(sample_tick), 0);
    check("rst_underrun", int'(underrun), 0);
    rst = 1'b0;
    tb_cnt = 0;

    feed_at = 10;
    feed_val = 200;
    run_period("rst0", 128, 0, 0);
    check("r1_tick", int'(sample_tick), 1);
    goto(20);
    sample_valid = 1'b1;
    sample_in = 9'd150;
    tick();
    sample_valid = 1'b0;
    goto(100);
    check("pre_rst_pwm", int'(pwm_out), 1);
    check("pre_rst_ready", int'(sample_ready), 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_pwm", int'(pwm_out), 0);
    check("mid_rst_ready", int'(sample_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tb_cnt = 0;
    run_period("post0", 128, 0, 0);
    run_period("post1", 128, 0, 1);

    for (int k = 0; k < 8; k++) apply_vec(k);

    run_period("urE", 100, 0, 1);
    volume = 5'd8;
    feed_at = 254;
    feed_val = 48;
    run_period("urF", 100, 0, 1);
    run_period("urG", 100, 0, 1);
    run_period("urH", 24, 1, 0);

    volume = 5'd16;
    sq[0] = 10;
    sq[1] = 20;
    sq[2] = 30;
    sidx = 0;
    sample_in = 9'd10;
    sample_valid = 1'b1;
    stream_on = 1'b1;
    run_period("sI", 24, 0, 1);
    run_period("s1", 10, 1, 0);
    mute_at = 5;
    mute_val = 1'b1;
    run_period("s2", 5, 1, 0);
    run_period("s3", 0, 1, 0);
    mute_at = 0;
    mute_val = 1'b0;
    run_period("s4", 30, 0, 1);
    check("stream_accepts", accepts, 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pwm_audio_out.md
# pwm_audio_out

Downstream consumer of the synthesizer's 9-bit unsigned sample stream (sine and other wave generators, values 0..255). It accepts one sample per PWM period through a valid/ready handshake, applies a 5-bit volume scale, and drives a single-bit PWM audio pin. It holds a one-entry input buffer, a two-stage scale pipeline, and a free-running period counter, and it reports underruns.

## Interface
- PWM_BITS, 8, PWM counter width; period = 2^PWM_BITS cycles (256)
- MAX_AMPLITUDE, 255, clamp ceiling for incoming samples; equals 2^PWM_BITS-1
- clk  in  1  system clock
- rst  in  1  reset; **one clock; reset is asynchronous and active-high**
- sample_in  in  9  unsigned sample
- sample_valid  in  1  sample_in is valid
- sample_ready  out  1  buffer can accept a sample; equals !buf_full
- volume  in  5  gain in 1/16 units; values above 16 saturate to 16 (unity)
- mute  in  1  forces pwm_out low
- pwm_out  out  1  registered PWM output
- sample_tick  out  1  one-cycle pulse when a new duty value takes effect
- underrun  out  1  one-cycle pulse when a period boundary finds the buffer empty

## Operation
- **Reset values (async, while rst high):**
  - cnt=0, buf_full=0, buf=0, pend=0, prod=0
  - duty=128 (midpoint, avoids a pop)
  - pwm_out=0, sample_tick=0, underrun=0
  - sample_ready reads 1.
- **Input buffer.** Accept when sample_valid && sample_ready:
  - buf <= min(sample_in, MAX_AMPLITUDE); buf_full <= 1.
  - A source that ignores ready loses samples. Sources must hold data until accepted.
- **Period counter.** cnt increments every cycle and wraps from 255 to 0.
- **Consume cycle (cnt==254):**
  - If buf_full (pre-accept value): prod <= buf * vol_sat (13-bit product); buf_full <= 0; pend <= 1.
  - Otherwise: pend <= 0; underrun pulses on the next cycle.
  - A sample accepted during cnt==254 while empty stays in the buffer for the following period.
  - At cnt==254 with buf_full=1, sample_ready=0, so accept and consume never collide.
- **Load cycle (cnt==255):**
  - If pend: duty <= prod >> 4 (max 255*16>>4 = 255; the result always fits in 8 bits); sample_tick pulses on the next cycle.
  - Otherwise duty holds its last value.
- **PWM.**
  - pwm_out <= (cnt < duty) && !mute, registered.
  - duty=0 gives a constant low; duty=255 gives 255 high cycles of 256. Full-on is not reachable.
- **Mute.**
  - Affects only pwm_out, from the next cycle.
  - Buffer, consume, underrun and sample_tick keep running, so samples are still drained.
- **Volume.**
  - Sampled at the consume cycle only.
  - A change mid-period takes effect with the next consumed sample.

## Timing
- Period: 256 cycles.
- Sample latency:
  - A sample buffered before cnt==254 is multiplied at 254 and loaded into duty at 255.
  - duty is compared from cnt==0 of the next period.
  - pwm_out reflects it one cycle later: cycles 1..duty after the cnt==0 edge.
- sample_tick and underrun are registered. They are high during the cycle with cnt==0 of the period they describe. They are never high together.
- sample_ready deasserts the cycle after an accept. It reasserts the cycle after cnt==254.
- Throughput: at most one sample per period. A source holding valid high is drained once per period.
- **rst asserted mid-period:** the following take effect immediately without waiting for a clock edge:
  - pwm_out drops.
  - The buffered sample is discarded.
  - duty returns to 128.
- **After rst release:** cnt starts at 0. The first period uses duty=128.

## Test plan
- Reset mid-period with buf_full=1 and duty=200:
  - pwm_out=0 and sample_ready=1 immediately.
  - After release, pwm_out is high exactly 128 of every 256 cycles.
  - No underrun is missed: the first boundary with no sample pulses underrun.
- sample_in=64, volume=16, accepted at cnt=10:
  - sample_tick pulses at next cnt==0.
  - pwm_out is high for 64 cycles in that period.
  - sample_ready is low from cnt=11 to 254.
- sample_in=300 (over range), volume=16 → clamped to 255; pwm_out high 255 of 256 cycles. Then volume=31 with sample 255 → saturates to 16, same 255 cycles.
- sample_in=200, volume=8 → duty=100. Volume=0 → duty=0, pwm_out constant low, sample_tick still pulses.
- No sample for two periods after duty=100:
  - underrun pulses once per boundary.
  - duty stays 100; sample_tick stays low.
  - A sample arriving exactly at cnt==254 is used one period later, not flagged twice.
- Back-to-back samples 10, 20, 30 with valid held high:
  - Each is accepted once per period, in order; duties are 10, 20, 30.
  - Asserting mute during the second period forces pwm_out low from the next cycle, while the third sample is still consumed and ticked.
